// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, jump flushes and multi-cycle
// multiply holds, with a saturating count of PC-stalled cycles.
module hazard_ctrl #(
   parameter int unsigned MUL_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        idex_memread,
   input  logic [4:0]  idex_rt,
   input  logic [4:0]  ifid_rs,
   input  logic [4:0]  ifid_rt,
   input  logic        ifid_uses_rt,
   input  logic        jump_taken,
   input  logic        mul_start,
   output logic        pc_write,
   output logic        ifid_write,
   output logic        ifid_flush,
   output logic        idex_bubble,
   output logic        exmem_hold,
   output logic        mul_busy,
   output logic [15:0] stall_count
);

   typedef enum logic {StRun, StMulWait} state_t;

   state_t      state_q, state_d;
   logic [7:0]  mcnt_q, mcnt_d;
   logic [15:0] stall_count_q;
   logic        load_use;

   assign load_use = idex_memread && (idex_rt != 5'd0) &&
                     ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));

   always_comb begin
      state_d     = state_q;
      mcnt_d      = mcnt_q;
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      exmem_hold  = 1'b0;
      mul_busy    = 1'b0;
      if (rst) begin
         state_d = StRun;
         mcnt_d  = 8'd0;
      end else begin
         unique case (state_q)
            StRun: begin
               // Jump outranks both multiply start and load-use.
               if (jump_taken) begin
                  ifid_flush  = 1'b1;
                  idex_bubble = 1'b1;
               end else if (mul_start) begin
                  state_d    = StMulWait;
                  mcnt_d     = 8'(MUL_CYCLES - 1);
                  pc_write   = 1'b0;
                  ifid_write = 1'b0;
                  exmem_hold = 1'b1;
               end else if (load_use) begin
                  pc_write    = 1'b0;
                  ifid_write  = 1'b0;
                  idex_bubble = 1'b1;
               end
            end
            StMulWait: begin
               mul_busy   = 1'b1;
               pc_write   = 1'b0;
               ifid_write = 1'b0;
               exmem_hold = 1'b1;
               mcnt_d     = mcnt_q - 8'd1;
               if (mcnt_q <= 8'd1) begin
                  state_d = StRun;
               end
            end
            default: state_d = StRun;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= StRun;
         mcnt_q        <= 8'd0;
         stall_count_q <= 16'd0;
      end else begin
         state_q <= state_d;
         mcnt_q  <= mcnt_d;
         if (!pc_write && (stall_count_q != 16'hFFFF)) begin
            stall_count_q <= stall_count_q + 16'd1;
         end
      end
   end

   assign stall_count = stall_count_q;

endmodule
